// File: rtl/count_src_seq_if.sv
// rtl/count_src_seq_if.sv - counter operand stream between the source and the sum/carry stage
interface count_src_seq_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] counter;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output counter,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  counter,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_src_seq.sv
// rtl/count_src_seq.sv - burst counter source: programmable start, up/down step, length, handshake
module count_src_seq #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [LEN_W-1:0]    burst_len,
    count_src_seq_if.master     src,
    output logic                wrap,
    output logic                done,
    output logic                busy
);
    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_run  = 2'd1,
        s_done = 2'd2
    } state_t;

    localparam logic [WIDTH:0] step_x = (WIDTH+1)'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               dir_q, dir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               stop_pend_q, stop_pend_d;

    logic               accept;
    logic [WIDTH:0]     sum_up;
    logic [WIDTH:0]     diff_dn;
    logic [LEN_W:0]     cnt_plus;
    logic               last_beat;

    // Extra top bit of the widened add/sub is the carry or borrow that drives wrap.
    assign sum_up    = {1'b0, counter_q} + step_x;
    assign diff_dn   = {1'b0, counter_q} - step_x;
    assign cnt_plus  = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
    assign last_beat = (len_q != '0) && (cnt_plus == {1'b0, len_q});
    assign accept    = valid_q && src.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= s_idle;
            counter_q   <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dir_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        valid_d     = valid_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        dir_d       = dir_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            s_idle: begin
                if (start && !stop) begin
                    state_d     = s_run;
                    counter_d   = load_val;
                    dir_d       = dir;
                    len_d       = burst_len;
                    cnt_d       = '0;
                    valid_d     = 1'b1;
                    stop_pend_d = 1'b0;
                end
            end
            s_run: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    counter_d = dir_q ? diff_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
                    wrap_d    = dir_q ? diff_dn[WIDTH] : sum_up[WIDTH];
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_plus[LEN_W-1:0];
                    // A stop seen on the accepting cycle still lets that beat count.
                    if (last_beat || stop || stop_pend_q) begin
                        state_d = s_done;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            s_done: begin
                state_d     = s_idle;
                stop_pend_d = 1'b0;
            end
            default: begin
                state_d = s_idle;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != s_idle);
    end

    assign src.counter   = counter_q;
    assign src.out_valid = valid_q;
    assign wrap          = wrap_q;
    assign done          = done_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_count_src_seq.sv
// tb/tb_count_src_seq.sv - checks count_src_seq (STEP=1 and STEP=3 builds) against a burst model
module tb_count_src_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [7:0] burst_len = 8'd0;
    logic       ready = 1'b0;
    logic       wrap1, done1, busy1;
    logic       wrap3, done3, busy3;

    int errors = 0;
    int checks = 0;

    count_src_seq_if #(.WIDTH(4)) ifc1 ();
    count_src_seq_if #(.WIDTH(4)) ifc3 ();
    assign ifc1.out_ready = ready;
    assign ifc3.out_ready = ready;

    count_src_seq #(.WIDTH(4), .STEP(1), .LEN_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load_val(load_val), .burst_len(burst_len), .src(ifc1.master),
        .wrap(wrap1), .done(done1), .busy(busy1)
    );

    count_src_seq #(.WIDTH(4), .STEP(3), .LEN_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load_val(load_val), .burst_len(burst_len), .src(ifc3.master),
        .wrap(wrap3), .done(done3), .busy(busy3)
    );

    always #5 clk = ~clk;

    // Burst-level model: beat k of a burst carries load +/- k*step mod 16.
    typedef struct {
        bit active;
        bit done_due;
        bit wrap_due;
        bit stop_p;
        bit dir;
        int k;
        int len;
        int load;
    } model_t;

    model_t m1, m3;
    logic [3:0] q1[$];
    logic [3:0] q3[$];

    function automatic int beat_value(model_t m, int step);
        int off;
        off = (m.k * step) % 16;
        return m.dir ? (m.load - off + 16) % 16 : (m.load + off) % 16;
    endfunction

    function automatic model_t model_next(model_t m, logic r, logic s, logic p, logic d,
                                          logic [3:0] lv, logic [7:0] bl, logic rdy, int step);
        model_t n;
        int v;
        int raw;
        n = m;
        n.wrap_due = 1'b0;
        n.done_due = 1'b0;
        if (r) begin
            n = '{default: 0};
        end else if (m.done_due) begin
            n.stop_p = 1'b0;
        end else if (m.active) begin
            if (p) n.stop_p = 1'b1;
            if (rdy) begin
                v   = beat_value(m, step);
                raw = m.dir ? v - step : v + step;
                n.wrap_due = (raw < 0) || (raw > 15);
                n.k = m.k + 1;
                if ((m.len != 0 && n.k == m.len) || n.stop_p) begin
                    n.active   = 1'b0;
                    n.done_due = 1'b1;
                    n.stop_p   = 1'b0;
                end
            end
        end else if (s && !p) begin
            n.active = 1'b1;
            n.dir    = d;
            n.load   = int'(lv);
            n.len    = int'(bl);
            n.k      = 0;
            n.stop_p = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag, input model_t m, input int step,
                             input logic [3:0] c, input logic v, input logic w,
                             input logic d, input logic b);
        chk({tag, "_counter"}, int'(c), beat_value(m, step));
        chk({tag, "_valid"}, int'(v), int'(m.active));
        chk({tag, "_wrap"}, int'(w), int'(m.wrap_due));
        chk({tag, "_done"}, int'(d), int'(m.done_due));
        chk({tag, "_busy"}, int'(b), int'(m.active | m.done_due));
    endtask

    task automatic tick();
        if (ifc1.out_valid && ready) q1.push_back(ifc1.counter);
        if (ifc3.out_valid && ready) q3.push_back(ifc3.counter);
        m1 = model_next(m1, rst, start, stop, dir, load_val, burst_len, ready, 1);
        m3 = model_next(m3, rst, start, stop, dir, load_val, burst_len, ready, 3);
        @(posedge clk);
        #1;
        chk_model("s1", m1, 1, ifc1.counter, ifc1.out_valid, wrap1, done1, busy1);
        chk_model("s3", m3, 3, ifc3.counter, ifc3.out_valid, wrap3, done3, busy3);
    endtask

    typedef struct {
        logic       rst, start, stop, dir;
        logic [3:0] load;
        logic [7:0] len;
        logic       ready;
        logic [3:0] e_cnt;
        logic       e_v, e_w, e_d, e_b;
    } vec_t;

    vec_t vecs[16];

    initial begin
        m1 = '{default: 0};
        m3 = '{default: 0};

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 8'd4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 8'd4, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 8'd4, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 8'd4, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 8'd9, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 8'd4, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 8'd4, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 8'd1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 8'd1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 8'd1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 8'd3, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd3, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'd3, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd3, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd3, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop; dir = vecs[i].dir;
            load_val = vecs[i].load; burst_len = vecs[i].len; ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_counter", i), int'(ifc1.counter), int'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_valid", i), int'(ifc1.out_valid), int'(vecs[i].e_v));
            chk($sformatf("vec%0d_wrap", i), int'(wrap1), int'(vecs[i].e_w));
            chk($sformatf("vec%0d_done", i), int'(done1), int'(vecs[i].e_d));
            chk($sformatf("vec%0d_busy", i), int'(busy1), int'(vecs[i].e_b));
        end
        start = 1'b0; stop = 1'b0; ready = 1'b0;
        tick();

        // Reset held three cycles in the middle of a free-running burst.
        start = 1'b1; dir = 1'b0; load_val = 4'h3; burst_len = 8'd0; ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t1_counter", int'(ifc1.counter), 0);
        chk("t1_valid", int'(ifc1.out_valid), 0);
        chk("t1_done", int'(done1), 0);
        chk("t1_busy", int'(busy1), 0);
        tick(); tick();
        rst = 1'b0; ready = 1'b0;
        tick();

        // Backpressure on the first beat.
        q1.delete(); q3.delete();
        start = 1'b1; dir = 1'b0; load_val = 4'h2; burst_len = 8'd3; ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_counter", int'(ifc1.counter), 2);
            chk("t3_hold_valid", int'(ifc1.out_valid), 1);
        end
        ready = 1'b1;
        for (int i = 0; i < 10 && !done1; i++) tick();
        chk("t3_done_seen", int'(done1), 1);
        chk("t3_nbeats", q1.size(), 3);
        for (int i = 0; i < 3 && i < q1.size(); i++) chk($sformatf("t3_beat%0d", i), int'(q1[i]), 2 + i);
        tick();

        // Down count: STEP=3 build gives 1,E,B and STEP=1 build gives 1,0,F.
        q1.delete(); q3.delete();
        start = 1'b1; dir = 1'b1; load_val = 4'h1; burst_len = 8'd3; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !done3; i++) tick();
        chk("t4_done_seen", int'(done3), 1);
        chk("t4_nbeats3", q3.size(), 3);
        if (q3.size() == 3) begin
            chk("t4_s3_b0", int'(q3[0]), 1);
            chk("t4_s3_b1", int'(q3[1]), 14);
            chk("t4_s3_b2", int'(q3[2]), 11);
        end
        chk("t4_nbeats1", q1.size(), 3);
        if (q1.size() == 3) begin
            chk("t4_s1_b1", int'(q1[1]), 0);
            chk("t4_s1_b2", int'(q1[2]), 15);
        end
        tick();

        // Free run stopped while beat 7 is stalled.
        q1.delete(); q3.delete();
        start = 1'b1; dir = 1'b0; load_val = 4'h0; burst_len = 8'd0; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && ifc1.counter != 4'h7; i++) tick();
        chk("t5_reach7", int'(ifc1.counter), 7);
        ready = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();
        chk("t5_hold_counter", int'(ifc1.counter), 7);
        chk("t5_hold_valid", int'(ifc1.out_valid), 1);
        ready = 1'b1;
        tick();
        chk("t5_done", int'(done1), 1);
        chk("t5_nbeats", q1.size(), 8);
        for (int i = 0; i < 8 && i < q1.size(); i++) chk($sformatf("t5_beat%0d", i), int'(q1[i]), i);
        tick();
        chk("t5_no_beat8", int'(ifc1.out_valid), 0);
        chk("t5_idle", int'(busy1), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 9) == 0);
            dir = 1'($urandom);
            load_val = 4'($urandom);
            burst_len = 8'($urandom_range(0, 5));
            ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
